vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480@60 Hz VGA output; sits directly upstream of the background/sprite pixel mappers.
- Produces the global pixel coordinates they consume, plus sync, blanking, playfield and frame/line markers.
- Counts a pixel tick, registers every output, and keeps coordinates and sync strictly cycle-aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low
- PLAY_X0, 96, first playfield column (inclusive)
- PLAY_X1, 544, playfield column end (exclusive)
- PLAY_Y0, 64, first playfield line (inclusive)
- PLAY_Y1, 448, playfield line end (exclusive)

Ports:
- clk  in  1  system clock (25 MHz on board)
- rst_n  in  1  asynchronous active-low reset
- tick_en  in  1  pixel-tick enable; tie high when clk is the pixel clock
- global_pixel_x  out  10  horizontal count, 0..H_TOTAL-1
- global_pixel_y  out  10  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_on  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- playfield_on  out  1  high when PLAY_X0<=x<PLAY_X1 and PLAY_Y0<=y<PLAY_Y1
- line_start  out  1  one-tick pulse when x==0
- frame_start  out  1  one-tick pulse when x==0 and y==0
- frame_count  out  8  frames completed since reset; wraps

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - Internal h_cnt/v_cnt advance only on clk edges with tick_en=1.
  - h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments on that wrap and wraps V_TOTAL-1 -> 0.
- Output register stage:
  - One register stage; every output decodes the (h_cnt,v_cnt) pair present before the edge. Latency is 1 tick.
  - All outputs describe the same coordinate in the same cycle.
- Sync windows:
  - hsync is asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), over whole lines.
- Coordinates in blanking: global_pixel_x/y carry raw counts during blanking; consumers gate with video_on.
- frame_count increments on the edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). 255 -> 0.
- tick_en=0:
  - Counters, coordinates, sync, video_on, playfield_on and frame_count hold.
  - line_start and frame_start are forced to 0, so each pulse lasts exactly one enabled tick.
- Reset (async assert, sync-to-clk release):
  - h_cnt=0, v_cnt=0, global_pixel_x=0, global_pixel_y=0.
  - hsync/vsync deasserted (1 when SYNC_ACTIVE_LOW).
  - video_on=0, playfield_on=0, line_start=0, frame_start=0, frame_count=0.
- First enabled tick after release: outputs show (0,0) with video_on=1, line_start=1, frame_start=1; frame_count stays 0.
- Reset mid-frame: all state returns to the reset values immediately; no partial-frame completion and no frame_count increment.
- Widths and comparisons:
  - Comparisons are unsigned, 10-bit.
  - Parameter sums must fit in 10 bits (H_TOTAL<=1024, V_TOTAL<=1024); elaboration-time check.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480 timing constants;
  - H_TOTAL/V_TOTAL;
  - playfield bounds, reused by the pixel mappers (tile size 32, origin 96/64);
  - the coordinate width constant (10).
- One natural sub-module, axis_counter:
  - parameterised modulus counter with enable, a wrap output and a registered window decode (start/end);
  - instantiated once for H and once for V, with V enabled by the H wrap.

Test Plan:
- Reset held 5 cycles, release, tick_en=1 -> first output cycle x=0,y=0,video_on=1,line_start=1,frame_start=1,hsync=1,vsync=1,frame_count=0.
- Run one line -> hsync low exactly for x=656..751 (96 ticks); video_on falls at x=640; x wraps 799->0 and y goes 0->1 on the same output cycle.
- Run a full frame (420000 ticks) -> vsync low for y=490..491 only; frame_start pulses once; frame_count=1; next frame_start is exactly 420000 ticks later.
- Toggle tick_en with a 50% duty pattern -> coordinate sequence identical to the tick_en=1 run; line_start/frame_start high for exactly one enabled cycle each.
- Sample x=95/96 and 543/544 on y=64, and y=63/448 -> playfield_on is 0/1, 1/0 and 0/0 respectively, matching the bounds.
- Assert rst_n at x=300,y=200 mid-frame -> all outputs return to reset values asynchronously; after release, counting restarts at (0,0) with frame_count=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the playfield geometry used by the
// timing generator and the downstream background/sprite pixel mappers.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Playfield is a 14x12 grid of 32-pixel tiles with its origin at (96,64).
    localparam int TILE_SIZE = 32;
    localparam int PLAY_X0   = 96;
    localparam int PLAY_X1   = 544;
    localparam int PLAY_Y0   = 64;
    localparam int PLAY_Y1   = 448;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test lo <= v < hi on unsigned coordinates.
    function automatic logic in_window(coord_t v, int lo, int hi);
        return (v >= coord_t'(lo)) && (v < coord_t'(hi));
    endfunction

endpackage

// File: rtl/axis_counter.sv
// One raster axis: modulus counter with increment enable, a wrap strobe and
// registered decodes (coordinate, active, sync, playfield, first-position).
module axis_counter
    import vga_pkg::*;
#(
    parameter int MODULUS    = VGA_H_TOTAL,
    parameter int ACT_END    = VGA_H_ACTIVE,
    parameter int SYNC_START = VGA_H_ACTIVE + VGA_H_FP,
    parameter int SYNC_END   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC,
    parameter int PLAY_START = PLAY_X0,
    parameter int PLAY_END   = PLAY_X1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   tick,
    input  logic   inc,
    output coord_t cnt_q,
    output logic   wrap,
    output logic   active_q,
    output logic   sync_q,
    output logic   play_q,
    output logic   first_q
);

    localparam coord_t LAST = coord_t'(MODULUS - 1);

    coord_t cnt;

    assign wrap = inc && (cnt == LAST);

    // The decode stage samples on every pixel tick, not only when this axis
    // advances, so the vertical flags stay aligned with the horizontal ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            sync_q   <= 1'b0;
            play_q   <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            first_q <= tick && (cnt == '0);
            if (inc) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
            if (tick) begin
                cnt_q    <= cnt;
                active_q <= in_window(cnt, 0, ACT_END);
                sync_q   <= in_window(cnt, SYNC_START, SYNC_END);
                play_q   <= in_window(cnt, PLAY_START, PLAY_END);
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: global pixel coordinates, sync,
// blanking, playfield and line/frame markers, all one tick behind the counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int PLAY_X0         = vga_pkg::PLAY_X0,
    parameter int PLAY_X1         = vga_pkg::PLAY_X1,
    parameter int PLAY_Y0         = vga_pkg::PLAY_Y0,
    parameter int PLAY_Y1         = vga_pkg::PLAY_Y1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_en,
    output logic [COORD_W-1:0] global_pixel_x,
    output logic [COORD_W-1:0] global_pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               playfield_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_totals
        $error("vga_timing_gen: raster totals do not fit the coordinate width");
    end

    coord_t h_cnt_q, v_cnt_q;
    logic   h_wrap, v_wrap;
    logic   h_act_q, h_sync_q, h_play_q, h_first_q;
    logic   v_act_q, v_sync_q, v_play_q, v_first_q;

    axis_counter #(
        .MODULUS    (H_TOTAL),
        .ACT_END    (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
        .PLAY_START (PLAY_X0),
        .PLAY_END   (PLAY_X1)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick_en),
        .inc      (tick_en),
        .cnt_q    (h_cnt_q),
        .wrap     (h_wrap),
        .active_q (h_act_q),
        .sync_q   (h_sync_q),
        .play_q   (h_play_q),
        .first_q  (h_first_q)
    );

    axis_counter #(
        .MODULUS    (V_TOTAL),
        .ACT_END    (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
        .PLAY_START (PLAY_Y0),
        .PLAY_END   (PLAY_Y1)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick_en),
        .inc      (h_wrap),
        .cnt_q    (v_cnt_q),
        .wrap     (v_wrap),
        .active_q (v_act_q),
        .sync_q   (v_sync_q),
        .play_q   (v_play_q),
        .first_q  (v_first_q)
    );

    // v_wrap already implies h_wrap and tick_en: this is the last-pixel edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= 8'd0;
        end else if (v_wrap) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    assign global_pixel_x = h_cnt_q;
    assign global_pixel_y = v_cnt_q;
    assign hsync          = h_sync_q ^ SYNC_ACTIVE_LOW;
    assign vsync          = v_sync_q ^ SYNC_ACTIVE_LOW;
    assign video_on       = h_act_q & v_act_q;
    assign playfield_on   = h_play_q & v_play_q;
    assign line_start     = h_first_q;
    assign frame_start    = h_first_q & v_first_q;

endmodule
